// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned CNT_WIDTH     = $clog2(DEFAULT_WIDTH);

    // Step counter width for a given operand width (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/addsub_stage_module.sv
// Combinational ripple add/subtract stage: sum = a + (b ^ {s}) + s.
module addsub_stage_module #(
    parameter int unsigned width = 5
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             s,
    output logic [width-1:0] sum,
    output logic             cout
);

    // Bit-serial ripple chain; s both inverts b and supplies the carry-in.
    always_comb begin
        logic carry;
        logic bx;
        sum   = '0;
        carry = s;
        for (int unsigned i = 0; i < width; i++) begin
            bx     = b[i] ^ s;
            sum[i] = a[i] ^ bx ^ carry;
            carry  = (a[i] & bx) | (carry & (a[i] ^ bx));
        end
        cout = carry;
    end

endmodule

// File: rtl/restoring_divider_module.sv
// Sequential unsigned restoring divider: one trial subtraction per cycle.
module restoring_divider_module
    import divider_pkg::*;
#(
    parameter int unsigned width = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = cnt_width(width);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [width-1:0] r_q, r_d;
    logic [width-1:0] q_q, q_d;
    logic [width-1:0] dvs_q, dvs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [width-1:0] quot_q, quot_d;
    logic [width-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [width:0]   s_w;
    logic [width:0]   t_w;
    logic             cout_w;
    logic             neg_w;
    logic [width-1:0] r_next;
    logic [width-1:0] q_next;

    // The kept partial remainder is always below the divisor, so its top
    // bit is zero and R is stored in width bits.
    assign s_w = {r_q, q_q[width-1]};

    addsub_stage_module #(
        .width (width + 1)
    ) u_addsub (
        .a    (s_w),
        .b    ({1'b0, dvs_q}),
        .s    (1'b1),
        .sum  (t_w),
        .cout (cout_w)
    );

    // Sign bit and borrow agree here because S < 2*divisor.
    assign neg_w  = t_w[width] & ~cout_w;
    assign r_next = neg_w ? s_w[width-1:0] : t_w[width-1:0];
    assign q_next = {q_q[width-2:0], ~neg_w};

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvs_d = divisor;
                    r_d   = '0;
                    q_d   = dividend;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(width - 1)) begin
                    quot_d  = q_next;
                    rem_d   = r_next;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_module.sv
// Directed self-checking bench for restoring_divider_module (width = 4).
module tb_restoring_divider_module;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_assert;
    int n_fail;

    restoring_divider_module #(
        .width (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive a start with operands; returns 1 time unit after the accepting edge.
    task automatic launch(input logic [3:0] a, input logic [3:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called right after the accepting edge; waits for done and checks results.
    task automatic finish_check(input string tag, input logic [3:0] b,
                                input logic [3:0] eq, input logic [3:0] er,
                                input logic edbz);
        int c;
        int busy_err;
        c = 0;
        busy_err = 0;
        while (done !== 1'b1 && c < 20) begin
            if (busy !== (b != 4'd0)) busy_err++;
            @(posedge clk); #1;
            c++;
        end
        chk({tag, ".done"}, done, 1);
        if (b != 4'd0) chk({tag, ".latency"}, c, 4);
        else           chk({tag, ".dbz_latency"}, (c <= 1), 1);
        chk({tag, ".busy_profile"}, busy_err, 0);
        chk({tag, ".busy_at_done"}, busy, 0);
        chk({tag, ".q"}, quotient, eq);
        chk({tag, ".r"}, remainder, er);
        chk({tag, ".dbz"}, div_by_zero, edbz);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, done, 0);
        chk({tag, ".q_hold"}, quotient, eq);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.q", quotient, 0);
        chk("rst.r", remainder, 0);
        chk("rst.dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 13 / 3
        launch(4'd13, 4'd3);
        chk("d13_3.busy_first", busy, 1);
        finish_check("d13_3", 4'd3, 4'd4, 4'd1, 1'b0);

        // Back-to-back at the first legal edge
        launch(4'd15, 4'd1);
        finish_check("d15_1", 4'd1, 4'd15, 4'd0, 1'b0);
        launch(4'd5, 4'd7);
        finish_check("d5_7", 4'd7, 4'd0, 4'd5, 1'b0);

        // Divide by zero, then a normal division clears the flag
        launch(4'd9, 4'd0);
        finish_check("d9_0", 4'd0, 4'd15, 4'd9, 1'b1);
        launch(4'd8, 4'd2);
        finish_check("d8_2", 4'd2, 4'd4, 4'd0, 1'b0);

        // start held through RUN with other operands
        launch(4'd14, 4'd5);
        start    = 1'b1;
        dividend = 4'd6;
        divisor  = 4'd4;
        begin
            int c;
            c = 0;
            while (done !== 1'b1 && c < 20) begin
                @(posedge clk); #1;
                c++;
            end
            chk("held.latency", c, 4);
            chk("held.q", quotient, 2);
            chk("held.r", remainder, 4);
            @(posedge clk); #1;
            chk("held.idle_busy", busy, 0);
            chk("held.idle_done", done, 0);
            @(posedge clk); #1;
            chk("held.accepted", busy, 1);
            start = 1'b0;
            finish_check("held2", 4'd4, 4'd1, 4'd2, 1'b0);
        end

        // Asynchronous reset mid-RUN
        launch(4'd11, 4'd3);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst.busy", busy, 0);
        chk("arst.q", quotient, 0);
        chk("arst.r", remainder, 0);
        chk("arst.done", done, 0);
        chk("arst.dbz", div_by_zero, 0);
        begin
            int seen;
            seen = 0;
            repeat (6) begin
                @(posedge clk); #1;
                if (done !== 1'b0) seen++;
            end
            chk("arst.no_done", seen, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        launch(4'd7, 4'd2);
        chk("post_rst.busy_first", busy, 1);
        finish_check("d7_2", 4'd2, 4'd3, 4'd1, 1'b0);

        // Exhaustive sweep against integer reference
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [3:0] eq;
                logic [3:0] er;
                logic       ez;
                if (b == 0) begin
                    eq = 4'hF;
                    er = 4'(a);
                    ez = 1'b1;
                end else begin
                    eq = 4'(a / b);
                    er = 4'(a % b);
                    ez = 1'b0;
                end
                launch(4'(a), 4'(b));
                finish_check($sformatf("sweep_%0d_%0d", a, b), 4'(b), eq, er, ez);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
